add_req_initiator: RTL and testbench

- Initiator and consumer end of the start/valid single-op adder protocol (a, b, start -> y, valid).
- Accepts operand pairs from an upstream valid/ready stream and issues each pair to the adder as a one-cycle start pulse.
- Waits for the adder's valid, checks y against a locally computed sum with a timeout, and returns the result on a downstream valid/ready stream.
- One transaction outstanding at a time; keeps transaction and error counters.

---
 rtl/add_if_pkg.sv | 25 ++
 rtl/add_req_initiator.sv | 137 +++++++++++++
 tb/tb_add_req_initiator.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/add_if_pkg.sv
// Shared types and helpers for the start/valid single-op adder protocol.
// The sum helper takes a runtime width so any instantiated W can use it.
package add_if_pkg;

   localparam int W_DEF       = 8;
   localparam int TIMEOUT_DEF = 4;
   localparam int CNT_W_DEF   = 16;
   localparam int MAX_W       = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2
   } state_e;

   // Wrapped w-bit sum; the carry out of bit w-1 is discarded.
   function automatic logic [MAX_W-1:0] exp_sum(input logic [MAX_W-1:0] a,
                                                input logic [MAX_W-1:0] b,
                                                input int unsigned      w);
      logic [MAX_W-1:0] mask;
      mask = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
      return (a + b) & mask;
   endfunction

endpackage

// File: rtl/add_req_initiator.sv
// Initiator/consumer for the start/valid adder: issues one operand pair at a time,
// checks the returned sum with a timeout, and hands the result downstream.
//
// state | meaning
// IDLE  | ready for an operand pair
// WAIT  | start issued, waiting for c_valid or timeout
// HOLD  | result presented downstream until out_ready
module add_req_initiator
   import add_if_pkg::*;
#(
   parameter int W       = W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_a,
   input  logic [W-1:0]     in_b,
   output logic             c_start,
   output logic [W-1:0]     c_a,
   output logic [W-1:0]     c_b,
   input  logic             c_valid,
   input  logic [W-1:0]     c_y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_sum,
   output logic             out_err,
   output logic             out_mismatch,
   output logic             proto_err,
   output logic [CNT_W-1:0] txn_count,
   output logic [CNT_W-1:0] err_count
);

   localparam int WC_W = $clog2(TIMEOUT + 1);

   state_e          state, state_nxt;
   logic [WC_W-1:0] wait_cnt;
   logic            accept;
   logic            got_valid;
   logic            timed_out;
   logic            handshake;
   logic            mismatch;
   logic            spurious;

   assign accept    = (state == IDLE) && in_valid;
   assign got_valid = (state == WAIT) && c_valid && !c_start;
   assign timed_out = (state == WAIT) && !c_valid && (wait_cnt == WC_W'(TIMEOUT - 1));
   assign handshake = (state == HOLD) && out_ready;
   assign mismatch  = (c_y != W'(exp_sum(MAX_W'(c_a), MAX_W'(c_b), W)));
   // A response in the start cycle itself is a zero-latency protocol violation.
   assign spurious  = c_valid && ((state != WAIT) || c_start);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (in_valid) state_nxt = WAIT;
         WAIT:    if (got_valid || timed_out) state_nxt = HOLD;
         HOLD:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Gated by rst_n so every output reads 0 while reset is held.
   always_comb begin
      in_ready = 1'b0;
      if (rst_n && (state == IDLE)) in_ready = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c_start  <= 1'b0;
         c_a      <= '0;
         c_b      <= '0;
         wait_cnt <= '0;
      end else begin
         if (accept) begin
            c_a      <= in_a;
            c_b      <= in_b;
            c_start  <= 1'b1;
            wait_cnt <= '0;
         end else begin
            c_start <= 1'b0;
         end
         if ((state == WAIT) && !c_valid && !c_start && !timed_out) begin
            wait_cnt <= wait_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid    <= 1'b0;
         out_sum      <= '0;
         out_err      <= 1'b0;
         out_mismatch <= 1'b0;
      end else if (got_valid) begin
         out_valid    <= 1'b1;
         out_sum      <= c_y;
         out_err      <= mismatch;
         out_mismatch <= mismatch;
      end else if (timed_out) begin
         out_valid    <= 1'b1;
         out_sum      <= '0;
         out_err      <= 1'b1;
         out_mismatch <= 1'b0;
      end else if (handshake) begin
         out_valid    <= 1'b0;
         out_err      <= 1'b0;
         out_mismatch <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         txn_count <= '0;
         err_count <= '0;
         proto_err <= 1'b0;
      end else begin
         if (handshake) begin
            txn_count <= txn_count + 1'b1;
            if (out_err && !(&err_count)) err_count <= err_count + 1'b1;
         end
         if (spurious) proto_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_add_req_initiator.sv
// Scoreboard bench for add_req_initiator with a behavioural adder that can
// answer correctly, wrongly, never, or in the start cycle.
module tb_add_req_initiator;
   import add_if_pkg::*;

   localparam int W   = 8;
   localparam int TMO = 4;
   localparam int CW  = 16;

   logic          clk, rst_n;
   logic          in_valid, in_ready;
   logic [W-1:0]  in_a, in_b;
   logic          c_start;
   logic [W-1:0]  c_a, c_b;
   logic          c_valid;
   logic [W-1:0]  c_y;
   logic          out_valid, out_ready;
   logic [W-1:0]  out_sum;
   logic          out_err, out_mismatch, proto_err;
   logic [CW-1:0] txn_count, err_count;

   add_req_initiator #(.W(W), .TIMEOUT(TMO), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .c_start(c_start), .c_a(c_a), .c_b(c_b), .c_valid(c_valid), .c_y(c_y),
      .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
      .out_err(out_err), .out_mismatch(out_mismatch), .proto_err(proto_err),
      .txn_count(txn_count), .err_count(err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef enum int {M_OK = 0, M_BAD = 1, M_NONE = 2, M_ZERO = 3} mode_e;
   typedef struct {
      logic [W-1:0] sum;
      logic         err;
      logic         mm;
   } exp_t;

   exp_t  sbq[$];
   mode_e mode = M_NONE;
   int    errors = 0;
   int    checks = 0;
   int    exp_txn = 0;
   int    exp_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   // Adder model: responds relative to the cycle in which it sees c_start.
   initial begin
      c_valid = 1'b0;
      c_y     = '0;
      forever begin
         @(negedge clk);
         if (rst_n && c_start === 1'b1) begin
            case (mode)
               M_OK, M_BAD: begin
                  @(negedge clk);
                  c_y     = c_a + c_b + ((mode == M_BAD) ? 8'd1 : 8'd0);
                  c_valid = 1'b1;
                  @(negedge clk);
                  c_valid = 1'b0;
               end
               M_ZERO: begin
                  c_y     = c_a + c_b;
                  c_valid = 1'b1;
                  @(negedge clk);
                  @(negedge clk);
                  c_valid = 1'b0;
               end
               default: ;
            endcase
         end
      end
   end

   // Monitor: a result is consumed wherever out_valid meets out_ready.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (rst_n && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_result: got sum %0d with empty scoreboard", out_sum);
            end else begin
               e = sbq.pop_front();
               chk("out_sum", out_sum, e.sum);
               chk("out_err", out_err, e.err);
               chk("out_mismatch", out_mismatch, e.mm);
               exp_txn = (exp_txn + 1) % 65536;
               if (e.err && exp_err != 65535) exp_err++;
            end
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      c_valid = 1'b0;
      mode = M_NONE;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      exp_txn = 0;
      exp_err = 0;
      sbq.delete();
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n == 50) chk("in_ready_timeout", in_ready, 1);
   endtask

   task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b,
                          input mode_e m, input int hold);
      exp_t e;
      int   lat;
      int   want_lat;
      mode = m;
      wait_ready();
      in_valid = 1'b1;
      in_a = a;
      in_b = b;
      @(negedge clk);
      in_valid = 1'b0;
      case (m)
         M_BAD:   begin e.sum = 8'(exp_sum(64'(a), 64'(b), W)) + 8'd1; e.err = 1'b1; e.mm = 1'b1; end
         M_NONE:  begin e.sum = '0; e.err = 1'b1; e.mm = 1'b0; end
         default: begin e.sum = 8'(exp_sum(64'(a), 64'(b), W)); e.err = 1'b0; e.mm = 1'b0; end
      endcase
      sbq.push_back(e);
      want_lat = (m == M_NONE) ? TMO + 1 : 2;
      chk("c_start_first", c_start, 1);
      chk("c_a", c_a, a);
      chk("c_b", c_b, b);
      chk("in_ready_busy", in_ready, 0);
      @(negedge clk);
      lat = 1;
      chk("c_start_pulse", c_start, 0);
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk("latency", lat, want_lat);
      if (!out_valid) begin
         sbq.delete();
         return;
      end
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_valid", out_valid, 1);
         chk("hold_sum", out_sum, e.sum);
         chk("hold_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("post_valid", out_valid, 0);
      chk("post_in_ready", in_ready, 1);
      chk("txn_count", txn_count, exp_txn);
      chk("err_count", err_count, exp_err);
      chk("sum_kept", out_sum, e.sum);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0;
      in_a = '0;
      in_b = '0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_c_start", c_start, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_sum", out_sum, 0);
      chk("rst_proto_err", proto_err, 0);
      chk("rst_txn_count", txn_count, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_in_ready", in_ready, 1);

      run_txn(8'd3, 8'd4, M_OK, 0);
      run_txn(8'd200, 8'd100, M_OK, 0);
      run_txn(8'd200, 8'd100, M_BAD, 0);
      run_txn(8'd5, 8'd6, M_OK, 5);
      run_txn(8'd1, 8'd2, M_NONE, 0);
      run_txn(8'd9, 8'd9, M_OK, 2);
      chk("no_proto_err", proto_err, 0);

      // Spurious c_valid while idle.
      do_reset();
      c_valid = 1'b1;
      @(negedge clk);
      c_valid = 1'b0;
      chk("idle_spurious_proto", proto_err, 1);
      chk("idle_spurious_ready", in_ready, 1);
      chk("idle_spurious_valid", out_valid, 0);
      repeat (3) @(negedge clk);
      chk("proto_sticky", proto_err, 1);
      run_txn(8'd50, 8'd60, M_OK, 0);
      chk("proto_sticky_txn", proto_err, 1);

      // c_valid coinciding with c_start.
      do_reset();
      run_txn(8'd20, 8'd22, M_ZERO, 1);
      chk("zero_lat_proto", proto_err, 1);

      // Reset while waiting on the adder.
      do_reset();
      mode = M_NONE;
      wait_ready();
      in_valid = 1'b1;
      in_a = 8'd77;
      in_b = 8'd1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_c_start", c_start, 0);
      chk("midrst_c_a", c_a, 0);
      chk("midrst_in_ready", in_ready, 0);
      chk("midrst_out_valid", out_valid, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      exp_txn = 0;
      exp_err = 0;
      sbq.delete();
      c_valid = 1'b1;
      c_y = 8'd78;
      @(negedge clk);
      c_valid = 1'b0;
      chk("late_valid_proto", proto_err, 1);
      repeat (4) @(negedge clk);
      chk("late_valid_no_out", out_valid, 0);
      run_txn(8'd10, 8'd20, M_OK, 0);

      // Randomized traffic.
      do_reset();
      for (int i = 0; i < 40; i++) begin
         run_txn(8'($urandom), 8'($urandom), mode_e'($urandom_range(0, 2)), $urandom_range(0, 3));
      end
      chk("sb_empty", sbq.size(), 0);
      chk("rand_no_proto", proto_err, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
